// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front end of the ALU datapath. It collects a three-word command frame
//   (opcode, A, B) from a valid/ready byte stream and evaluates the selected
//   operation. The registered result and its Z/N/C flags are then presented
//   on a valid/ready output stream.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    command stream word (opcode, then A, then B)
//   in_valid   in_data valid
//   in_ready   sequencer can accept a word (IDLE, GET_A, GET_B)
//   res_data   registered result
//   flag_z     result equals zero
//   flag_n     result MSB
//   flag_c     carry / borrow / shifted-out bit
//   out_valid  result and flags valid
//   out_ready  downstream accepts result
//   busy       high whenever the FSM is not in IDLE
//
// States
//   IDLE  | waiting for opcode word
//   GET_A | waiting for operand A
//   GET_B | waiting for operand B
//   EXEC  | one cycle: register result and flags
//   OUT   | result presented, waiting for out_ready

module alu_op_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] res_data,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [2:0]   op_q;
    logic [N-1:0] a_q, b_q;
    logic         ld_op, ld_a, ld_b, ld_res;

    logic [N-1:0] res_nxt;
    logic         c_nxt;
    logic [N:0]   sum, diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_op     = 1'b0;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_res    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_op     = 1'b1;
                    state_nxt = GET_A;
                end
            end
            GET_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_a      = 1'b1;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_b      = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                ld_res    = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Carry and borrow come from the extra top bit of an N+1-bit add/subtract.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res_nxt = '0;
        c_nxt   = 1'b0;
        case (op_q)
            3'd0: res_nxt = a_q & b_q;
            3'd1: res_nxt = a_q | b_q;
            3'd2: res_nxt = a_q ^ b_q;
            3'd3: begin
                res_nxt = sum[N-1:0];
                c_nxt   = sum[N];
            end
            3'd4: begin
                res_nxt = diff[N-1:0];
                c_nxt   = diff[N];
            end
            3'd5: res_nxt = ~a_q;
            3'd6: begin
                res_nxt = {a_q[N-2:0], 1'b0};
                c_nxt   = a_q[N-1];
            end
            3'd7: begin
                res_nxt = {1'b0, a_q[N-1:1]};
                c_nxt   = a_q[0];
            end
            default: begin
                res_nxt = '0;
                c_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_data <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            // Only the low three bits of the opcode word select the operation.
            if (ld_op) op_q <= in_data[2:0];
            if (ld_a)  a_q  <= in_data;
            if (ld_b)  b_q  <= in_data;
            if (ld_res) begin
                res_data <= res_nxt;
                flag_z   <= (res_nxt == '0);
                flag_n   <= res_nxt[N-1];
                flag_c   <= c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] res_data;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_data  (res_data),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one word, wait (bounded) for in_ready, let it transfer.
    // Returns at the falling edge after the accepting rising edge.
    task automatic send_word(input logic [7:0] w, input bit keep_valid, input bit gap);
        int n;
        n        = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word timeout: in_ready stayed 0 for word 0x%0h", w);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    // Called at the falling edge after B was accepted, with out_ready=1.
    task automatic get_result(input vec_t v, input string name);
        int n;
        chk({name, " exec_out_valid"}, 8'(out_valid), 8'd0);
        chk({name, " exec_in_ready"}, 8'(in_ready), 8'd0);
        @(negedge clk);
        chk({name, " latency_out_valid"}, 8'(out_valid), 8'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, " res"}, res_data, v.res);
        chk({name, " z"}, 8'(flag_z), 8'(v.z));
        chk({name, " n"}, 8'(flag_n), 8'(v.n));
        chk({name, " c"}, 8'(flag_c), 8'(v.c));
        @(posedge clk);
        @(negedge clk);
        chk({name, " post_out_valid"}, 8'(out_valid), 8'd0);
        chk({name, " post_busy"}, 8'(busy), 8'd0);
        chk({name, " post_res_hold"}, res_data, v.res);
    endtask

    task automatic run_frame(input vec_t v, input bit gap, input string name);
        send_word(v.op, 1'b0, gap);
        send_word(v.a, 1'b0, gap);
        send_word(v.b, 1'b0, 1'b0);
        get_result(v, name);
    endtask

    vec_t hv;

    initial begin
        //            op     a      b      res    z     n     c
        vecs[0]  = '{8'h00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{8'h04, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{8'hFE, 8'h81, 8'hAA, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h07, 8'h81, 8'h5A, 8'h40, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h05, 8'h0F, 8'h77, 8'hF0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h01, 8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h02, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h03, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{8'h04, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'h06, 8'h40, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{8'h07, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{8'h00, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'h04, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{8'h0B, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst in_ready", 8'(in_ready), 8'd1);
        chk("rst out_valid", 8'(out_valid), 8'd0);
        chk("rst busy", 8'(busy), 8'd0);
        chk("rst res", res_data, 8'h00);
        chk("rst flags", {5'd0, flag_z, flag_n, flag_c}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: odd entries insert an in_valid gap after opcode and A.
        for (int i = 0; i < 15; i++) begin
            run_frame(vecs[i], (i % 2) == 1, $sformatf("vec%0d", i));
        end

        // Output backpressure: out_ready low for 5 clocks.
        out_ready = 1'b0;
        hv = '{8'h03, 8'h90, 8'h80, 8'h10, 1'b0, 1'b0, 1'b1};
        send_word(hv.op, 1'b0, 1'b0);
        send_word(hv.a, 1'b0, 1'b0);
        send_word(hv.b, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d out_valid", k), 8'(out_valid), 8'd1);
            chk($sformatf("bp%0d res", k), res_data, hv.res);
            chk($sformatf("bp%0d flags", k), {5'd0, flag_z, flag_n, flag_c}, {5'd0, hv.z, hv.n, hv.c});
            chk($sformatf("bp%0d in_ready", k), 8'(in_ready), 8'd0);
            chk($sformatf("bp%0d busy", k), 8'(busy), 8'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp release out_valid", 8'(out_valid), 8'd0);
        chk("bp release busy", 8'(busy), 8'd0);

        // Asynchronous reset mid-frame (after A), between clock edges.
        send_word(8'h03, 1'b0, 1'b0);
        send_word(8'h11, 1'b0, 1'b0);
        chk("pre_arst busy", 8'(busy), 8'd1);
        chk("pre_arst res", res_data, 8'h10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst in_ready", 8'(in_ready), 8'd1);
        chk("arst busy", 8'(busy), 8'd0);
        chk("arst out_valid", 8'(out_valid), 8'd0);
        chk("arst res", res_data, 8'h00);
        chk("arst flags", {5'd0, flag_z, flag_n, flag_c}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        hv = '{8'h01, 8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0, 1'b0};
        run_frame(hv, 1'b0, "after_arst");

        // Back-to-back frames, in_valid held high throughout.
        hv = '{8'h03, 8'h22, 8'h33, 8'h55, 1'b0, 1'b0, 1'b0};
        send_word(hv.op, 1'b1, 1'b0);
        send_word(hv.a, 1'b1, 1'b0);
        send_word(hv.b, 1'b1, 1'b0);
        in_data = 8'h04;
        chk("b2b exec in_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        chk("b2b out_valid", 8'(out_valid), 8'd1);
        chk("b2b res1", res_data, hv.res);
        @(negedge clk);
        chk("b2b idle busy", 8'(busy), 8'd0);
        chk("b2b idle in_ready", 8'(in_ready), 8'd1);
        @(negedge clk);
        chk("b2b op2 accepted", 8'(busy), 8'd1);
        chk("b2b op2 in_ready", 8'(in_ready), 8'd1);
        hv = '{8'h04, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b1, 1'b1};
        send_word(hv.a, 1'b1, 1'b0);
        send_word(hv.b, 1'b0, 1'b0);
        get_result(hv, "b2b frame2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
